// File: rtl/x2050_pkg.sv
// Shared definitions for the x2050 L-side adder input path: source encodings and stage states.
package x2050_pkg;

  typedef enum logic [2:0] {
    LX_ZERO   = 3'd0,
    LX_L      = 3'd1,
    LX_MSB    = 3'd2,
    LX_E      = 3'd3,
    LX_LHALF  = 3'd4,
    LX_LOR3   = 3'd5,
    LX_FOUR   = 3'd6,
    LX_TWOMSB = 3'd7
  } lx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAR  = 2'd1,
    ST_SER  = 2'd2
  } state_t;

endpackage

// File: rtl/x2050_ladsel.sv
// Combinational left-input source selector; I/O mode remaps the two constant sources onto the I/O register.
module x2050_ladsel
  import x2050_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_io_mode,
  input  logic [2:0]       i_lx,
  input  logic [3:0]       i_e,
  input  logic [WIDTH-1:0] i_l_reg,
  input  logic [1:0]       i_ioreg,
  output logic [WIDTH-1:0] o_src
);

  always_comb begin
    o_src = '0;
    case (lx_t'(i_lx))
      LX_ZERO:   o_src = '0;
      LX_L:      o_src = i_l_reg;
      LX_MSB:    o_src[WIDTH-1] = 1'b1;
      LX_E:      o_src[4:1] = i_e;
      LX_LHALF:  o_src[WIDTH-1:WIDTH/2] = i_l_reg[WIDTH/2-1:0];
      LX_LOR3: begin
        o_src      = i_l_reg;
        o_src[1:0] = 2'b11;
      end
      LX_FOUR: begin
        if (i_io_mode) o_src[1:0] = ~i_ioreg;
        else           o_src[2]   = 1'b1;
      end
      LX_TWOMSB: begin
        if (i_io_mode) o_src[1:0]             = i_ioreg;
        else           o_src[WIDTH-1:WIDTH-2] = 2'b11;
      end
      default:   o_src = '0;
    endcase
  end

endmodule

// File: rtl/x2050_ladp.sv
// L-side adder input stage: latches a selected operand on accept and delivers it whole or byte-serially.
// Handshake: a transfer happens on a cycle where valid & ready are both high; o_valid holds with stable data until taken.
module x2050_ladp
  import x2050_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int LANES = WIDTH / 8,
  localparam int LW    = $clog2(LANES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_io_mode,
  input  logic [2:0]       i_lx,
  input  logic             i_tc,
  input  logic             i_serial,
  input  logic [3:0]       i_e,
  input  logic [WIDTH-1:0] i_l_reg,
  input  logic [1:0]       i_ioreg,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_xin,
  output logic [WIDTH-1:0] o_xg,
  output logic [7:0]       o_byte,
  output logic [LW-1:0]    o_lane,
  output logic             o_last,
  output logic             o_cin,
  output logic             o_zero,
  output state_t           o_dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] r_xin;
  logic [WIDTH-1:0] w_xg;
  logic             r_tc;
  logic             r_zero;
  logic [LW-1:0]    r_lane;
  logic             w_accept;
  logic             w_fire;
  logic             w_lane_last;

  x2050_ladsel #(.WIDTH(WIDTH)) u_sel (
    .i_io_mode (i_io_mode),
    .i_lx      (i_lx),
    .i_e       (i_e),
    .i_l_reg   (i_l_reg),
    .i_ioreg   (i_ioreg),
    .o_src     (w_src)
  );

  assign w_accept    = i_valid & o_ready;
  assign w_fire      = o_valid & i_ready;
  assign w_lane_last = (r_lane == LW'(LANES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // A new accept on the final beat overrides the return to idle.
  always_comb begin
    w_next = r_state;
    if (w_fire && o_last) w_next = ST_IDLE;
    if (w_accept)         w_next = i_serial ? ST_SER : ST_PAR;
  end

  always_comb begin
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_cin   = 1'b0;
    case (r_state)
      ST_PAR: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_cin   = r_tc;
      end
      ST_SER: begin
        o_valid = 1'b1;
        o_last  = w_lane_last;
        o_cin   = r_tc & (r_lane == '0);
      end
      default: ;
    endcase
    o_ready = (r_state == ST_IDLE) | (o_valid & i_ready & o_last);
  end

  // r_tc resets to true so the gated operand reads zero out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_xin  <= '0;
      r_tc   <= 1'b1;
      r_zero <= 1'b0;
      r_lane <= '0;
    end else if (w_accept) begin
      r_xin  <= w_src;
      r_tc   <= i_tc;
      r_zero <= (w_src == '0);
      r_lane <= '0;
    end else if (w_fire && !o_last) begin
      r_lane <= r_lane + 1'b1;
    end
  end

  assign w_xg = r_xin ^ {WIDTH{~r_tc}};

  always_comb begin
    o_byte = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == LW'(k)) o_byte = w_xg[k*8 +: 8];
    end
  end

  assign o_xin       = r_xin;
  assign o_xg        = w_xg;
  assign o_lane      = r_lane;
  assign o_zero      = r_zero;
  assign o_dbg_state = r_state;

endmodule
